or_resp_checker: RTL and testbench
==================================

OR_RESP_CHECKER -- requirements
Module: or_resp_checker

Interface
REQ-001 Parameter MAX_LAT, default 3, response window length in cycles; legal range 1..15.
REQ-002 Parameter CNT_W, default 8, width of error and pass counters.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 a  input  1  request line A, sampled on posedge clk.
REQ-006 b  input  1  request line B, sampled on posedge clk.
REQ-007 w  input  1  response line, sampled on posedge clk.
REQ-008 busy  output  1  high while a response window is open.
REQ-009 pass  output  1  one-cycle pulse on a response inside the window.
REQ-010 fail  output  1  one-cycle pulse on window expiry without a response.
REQ-011 src  output  2  {a,b} captured at the trigger; held until the next trigger.
REQ-012 err_cnt  output  CNT_W  saturating count of fail events.
REQ-013 pass_cnt  output  CNT_W  saturating count of pass events.

Function
REQ-014 The trigger SHALL be a rising edge of (a|b): (a|b)=1 this cycle and 0 in the previous sampled cycle.
REQ-015 The FSM SHALL have three states, IDLE, WAIT and DONE; the reset state is IDLE.
REQ-016 IDLE->WAIT on trigger; in the same edge, src<={a,b} and the window counter is loaded with MAX_LAT.
REQ-017 In WAIT, w=1 SHALL move the FSM to DONE, assert pass for exactly the next cycle, and increment pass_cnt.
REQ-018 In WAIT with w=0, the window counter SHALL decrement; on reaching 0, the FSM moves to DONE, asserts fail for one cycle, and increments err_cnt.
REQ-019 DONE->IDLE unconditionally after one cycle; a trigger is not accepted in DONE.
REQ-020 w SHALL be checked in cycles 1..MAX_LAT after the trigger edge; w in the trigger cycle itself SHALL be ignored.
REQ-021 Triggers during WAIT or DONE SHALL be ignored; src is not overwritten.
REQ-022 w=1 on the last window cycle SHALL count as pass, not fail.
REQ-023 pass and fail SHALL never be high in the same cycle.
REQ-024 busy SHALL be 1 exactly when the state is WAIT.
REQ-025 Both counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-026 (a|b) held high continuously SHALL yield only one trigger.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, busy=0, pass=0, fail=0, src=0, err_cnt=0, pass_cnt=0, and the previous-(a|b) register to 0.
REQ-028 Reset asserted mid-window SHALL abort the window with no pass or fail pulse.
REQ-029 After rst_n deasserts, (a|b)=1 on the first edge SHALL count as a trigger.

Configuration
REQ-030 With OR_RESP_CHECKER_STICKY_EN defined, output fail_sticky (1 bit) SHALL be added; it sets on any fail pulse and clears only on reset.
REQ-031 Without OR_RESP_CHECKER_STICKY_EN, the port fail_sticky and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package or_resp_checker_pkg SHALL hold the state enum (IDLE, WAIT, DONE) and the constants LAT_MAX_LEGAL=15 and LAT_W=4.
REQ-033 Sub-module sat_counter (width parameter, inc, clear, count output) SHALL implement both counters.

Verification
REQ-034 Reset, then a=0 b=1 at cycle 3 and w=1 at cycle 5 (MAX_LAT=3) -> pass pulse at cycle 6, src=2'b01, pass_cnt=1, err_cnt=0.
REQ-035 a=1 b=0 trigger and w held 0 for 3 cycles -> fail pulse after the 3rd window cycle, err_cnt=1, busy low on the next cycle.
REQ-036 a=1 b=1 trigger with w=1 in the trigger cycle only -> w ignored, fail reported, src=2'b11.
REQ-037 Trigger, then a second rising edge of (a|b) during WAIT -> single pass or fail, src unchanged, one counter increments by 1.
REQ-038 CNT_W=2 with 5 consecutive fail windows -> err_cnt=3 after the 3rd and 4th and 5th fail; with STICKY_EN, fail_sticky=1.
REQ-039 rst_n pulsed low in the 2nd WAIT cycle -> no pass or fail pulse, all outputs 0, and a fresh trigger works normally afterwards.

Source files
------------

// File: rtl/or_resp_checker_pkg.sv
// -----------------------------------------------------------------------------
// or_resp_checker_pkg
// Shared types and constants for the OR-triggered response checker.
//   state_t       : checker FSM states (IDLE, WAIT, DONE)
//   LAT_MAX_LEGAL : largest supported response window, in cycles
//   LAT_W         : width of the window down-counter
// -----------------------------------------------------------------------------
package or_resp_checker_pkg;

   localparam int LAT_MAX_LEGAL = 15;
   localparam int LAT_W         = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Saturating increment used by the event counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
      logic [31:0] res;
      res = val;
      if (val < max) begin
         res = val + 32'd1;
      end else begin
         res = max;
      end
      return res;
   endfunction

endpackage

// File: rtl/or_resp_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that stops at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   clear : synchronous clear (wins over inc)
//   count : current count, W bits
// -----------------------------------------------------------------------------
module sat_counter
   import or_resp_checker_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] r_count;
   logic [W-1:0] w_count_nxt;
   logic [31:0]  w_inc_val;

   assign w_inc_val = sat_inc(32'(r_count), 32'(CNT_MAX));

   // Next-count selection: clear, saturating increment, or hold.
   always_comb begin
      w_count_nxt = r_count;
      if (clear) begin
         w_count_nxt = {W{1'b0}};
      end else if (inc) begin
         w_count_nxt = w_inc_val[W-1:0];
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= {W{1'b0}};
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/or_resp_checker.sv
// -----------------------------------------------------------------------------
// or_resp_checker
// Watches for a rising edge of (a|b); after it, expects w within MAX_LAT
// cycles. Reports a one-cycle pass or fail pulse and keeps saturating counts.
// Optional feature macro: OR_RESP_CHECKER_STICKY_EN adds fail_sticky.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   a, b        : request lines, trigger is rising edge of (a|b)
//   w           : response line, checked in cycles 1..MAX_LAT after trigger
//   busy        : response window open
//   pass, fail  : one-cycle outcome pulses
//   src         : {a,b} captured at the accepted trigger
//   err_cnt     : saturating count of fails
//   pass_cnt    : saturating count of passes
//   fail_sticky : (macro only) set by any fail, cleared only by reset
// MAX_LAT must lie in 1..LAT_MAX_LEGAL.
// -----------------------------------------------------------------------------
module or_resp_checker
   import or_resp_checker_pkg::*;
#(
   parameter int MAX_LAT = 3,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             w,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       src,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] pass_cnt
`ifdef OR_RESP_CHECKER_STICKY_EN
   ,
   output logic             fail_sticky
`endif
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MAX_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LAT_W-1:0] r_lat;
   logic [LAT_W-1:0] w_lat_nxt;
   logic             r_prev;
   logic [1:0]       r_src;
   logic             r_pass;
   logic             r_fail;
   logic             w_trig;
   logic             w_src_load;
   logic             w_pass_set;
   logic             w_fail_set;

   assign w_trig = (a | b) & ~r_prev;

   // Next-state, window counter and outcome decode.
   always_comb begin
      w_state_nxt = r_state;
      w_lat_nxt   = r_lat;
      w_src_load  = 1'b0;
      w_pass_set  = 1'b0;
      w_fail_set  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_trig) begin
               w_state_nxt = WAIT;
               w_lat_nxt   = LAT_INIT;
               w_src_load  = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            // A response on the final window cycle still counts as a pass.
            if (w) begin
               w_state_nxt = DONE;
               w_pass_set  = 1'b1;
            end else if (r_lat == LAT_ONE) begin
               w_state_nxt = DONE;
               w_lat_nxt   = {LAT_W{1'b0}};
               w_fail_set  = 1'b1;
            end else begin
               w_lat_nxt   = r_lat - LAT_ONE;
            end
         end
         DONE: begin
            // Single cooldown cycle; triggers seen here are dropped.
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_lat_nxt   = {LAT_W{1'b0}};
         end
      endcase
   end

   // State, window counter, edge detector, source capture and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_lat   <= {LAT_W{1'b0}};
         r_prev  <= 1'b0;
         r_src   <= 2'b00;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_lat   <= w_lat_nxt;
         r_prev  <= a | b;
         r_src   <= w_src_load ? {a, b} : r_src;
         r_pass  <= w_pass_set;
         r_fail  <= w_fail_set;
      end
   end

   assign busy = (r_state == WAIT);
   assign pass = r_pass;
   assign fail = r_fail;
   assign src  = r_src;

   sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_pass_set),
      .clear (1'b0),
      .count (pass_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_fail_set),
      .clear (1'b0),
      .count (err_cnt)
   );

`ifdef OR_RESP_CHECKER_STICKY_EN
   logic r_fail_sticky;

   // Sticky fail flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fail_sticky <= 1'b0;
      end else begin
         r_fail_sticky <= r_fail_sticky | w_fail_set;
      end
   end

   assign fail_sticky = r_fail_sticky;
`endif

endmodule

// File: tb/tb_or_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_or_resp_checker
// Drives two checkers from the same stimulus: dut1 with defaults
// (MAX_LAT=3, CNT_W=8) and dut2 with MAX_LAT=1, CNT_W=2. A cycle-counting
// model predicts every output for both; literal checks pin key points.
// -----------------------------------------------------------------------------
module tb_or_resp_checker;

   logic clk;
   logic rst_n;
   logic a, b, w;

   logic       busy1, pass1, fail1;
   logic [1:0] src1;
   logic [7:0] err1, pcnt1;
   logic       busy2, pass2, fail2;
   logic [1:0] src2;
   logic [1:0] err2, pcnt2;
`ifdef OR_RESP_CHECKER_STICKY_EN
   logic       stk1, stk2;
`endif

   int n_chk = 0;
   int n_err = 0;

   or_resp_checker dut1 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .w(w),
      .busy(busy1), .pass(pass1), .fail(fail1), .src(src1),
      .err_cnt(err1), .pass_cnt(pcnt1)
`ifdef OR_RESP_CHECKER_STICKY_EN
      , .fail_sticky(stk1)
`endif
   );

   or_resp_checker #(.MAX_LAT(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .w(w),
      .busy(busy2), .pass(pass2), .fail(fail2), .src(src2),
      .err_cnt(err2), .pass_cnt(pcnt2)
`ifdef OR_RESP_CHECKER_STICKY_EN
      , .fail_sticky(stk2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: cycle number of the trigger and of the last outcome decide
   // everything; the window is "open" between them.
   typedef struct {
      bit       open;
      int       n;
      int       t_trig;
      int       t_out;
      bit       prev;
      bit [1:0] src;
      bit       pass;
      bit       fail;
      int       err;
      int       pcnt;
      bit       sticky;
   } mdl_t;

   mdl_t m1, m2;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.open = 1'b0; m.n = 0; m.t_trig = 0; m.t_out = -10; m.prev = 1'b0;
      m.src = 2'b00; m.pass = 1'b0; m.fail = 1'b0; m.err = 0; m.pcnt = 0;
      m.sticky = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t mi, int lat, int cmax, bit av, bit bv, bit wv);
      mdl_t m;
      m = mi;
      m.n = m.n + 1;
      m.pass = 1'b0;
      m.fail = 1'b0;
      if (m.open) begin
         if (wv) begin
            m.pass = 1'b1; m.open = 1'b0; m.t_out = m.n;
            m.pcnt = (m.pcnt < cmax) ? m.pcnt + 1 : cmax;
         end else if (m.n - m.t_trig == lat) begin
            m.fail = 1'b1; m.open = 1'b0; m.t_out = m.n; m.sticky = 1'b1;
            m.err = (m.err < cmax) ? m.err + 1 : cmax;
         end
      end else if ((av | bv) && !m.prev && m.n != m.t_out + 1) begin
         m.open = 1'b1; m.t_trig = m.n; m.src = {av, bv};
      end
      m.prev = av | bv;
      return m;
   endfunction

   // Advance both models on each clock edge; reset clears them at once.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= mdl_reset();
         m2 <= mdl_reset();
      end else begin
         m1 <= mdl_step(m1, 3, 255, a, b, w);
         m2 <= mdl_step(m2, 1, 3, a, b, w);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output of both checkers against the model mid-cycle.
   always @(negedge clk) begin
      check("busy1", 32'(busy1), 32'(m1.open));
      check("pass1", 32'(pass1), 32'(m1.pass));
      check("fail1", 32'(fail1), 32'(m1.fail));
      check("src1",  32'(src1),  32'(m1.src));
      check("err1",  32'(err1),  32'(m1.err));
      check("pcnt1", 32'(pcnt1), 32'(m1.pcnt));
      check("busy2", 32'(busy2), 32'(m2.open));
      check("pass2", 32'(pass2), 32'(m2.pass));
      check("fail2", 32'(fail2), 32'(m2.fail));
      check("src2",  32'(src2),  32'(m2.src));
      check("err2",  32'(err2),  32'(m2.err));
      check("pcnt2", 32'(pcnt2), 32'(m2.pcnt));
      check("excl1", 32'(pass1 & fail1), 32'd0);
`ifdef OR_RESP_CHECKER_STICKY_EN
      check("stk1", 32'(stk1), 32'(m1.sticky));
      check("stk2", 32'(stk2), 32'(m2.sticky));
`endif
   end

   task automatic cyc(input bit av, input bit bv, input bit wv);
      a = av; b = bv; w = wv;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; a = 1'b0; b = 1'b0; w = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_src",  32'(src1),  32'd0);
      check("rst_err",  32'(err1),  32'd0);
      check("rst_pcnt", 32'(pcnt1), 32'd0);
      rst_n = 1'b1;

      // b trigger at cycle 3, w at cycle 5 -> pass at cycle 6
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 1);
      check("s1_pass", 32'(pass1), 32'd1);
      check("s1_src",  32'(src1),  32'd1);
      check("s1_pcnt", 32'(pcnt1), 32'd1);
      check("s1_err",  32'(err1),  32'd0);
      cyc(0, 0, 0); cyc(0, 0, 0);

      // a trigger, no response -> fail after the 3rd window cycle
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      check("s2_fail", 32'(fail1), 32'd1);
      check("s2_err",  32'(err1),  32'd1);
      cyc(0, 0, 0);
      check("s2_busy", 32'(busy1), 32'd0);

      // w only in the trigger cycle, (a|b) held high -> single window, fail
      cyc(0, 0, 0); cyc(1, 1, 1); cyc(1, 1, 0); cyc(1, 1, 0); cyc(0, 0, 0);
      check("s3_fail", 32'(fail1), 32'd1);
      check("s3_src",  32'(src1),  32'd3);
      check("s3_err",  32'(err1),  32'd2);
      check("s3_pcnt", 32'(pcnt1), 32'd1);
      cyc(0, 0, 0);

      // second rising edge during WAIT ignored; w on last window cycle passes
      cyc(0, 1, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 1);
      check("s4_pass", 32'(pass1), 32'd1);
      check("s4_fail", 32'(fail1), 32'd0);
      check("s4_src",  32'(src1),  32'd1);
      check("s4_pcnt", 32'(pcnt1), 32'd2);
      check("s4_err",  32'(err1),  32'd2);
      cyc(0, 0, 0); cyc(0, 0, 0);

      // fresh start, then 5 fail windows: dut2 err saturates at 3
      rst_n = 1'b0;
      #1;
      check("r2_err", 32'(err1), 32'd0);
      cyc(0, 0, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 0, 0); cyc(0, 0, 0);
         check("s5_fail2", 32'(fail2), 32'd1);
         check("s5_err2",  32'(err2),  (k < 3) ? 32'(k) : 32'd3);
         cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      end
      check("s5_err1", 32'(err1), 32'd5);
`ifdef OR_RESP_CHECKER_STICKY_EN
      check("s5_stk2", 32'(stk2), 32'd1);
`endif

      // reset in the 2nd WAIT cycle aborts the window silently
      cyc(1, 0, 0); cyc(0, 0, 0);
      check("s6_busy_pre", 32'(busy1), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("s6_busy", 32'(busy1), 32'd0);
      check("s6_src",  32'(src1),  32'd0);
      check("s6_err",  32'(err1),  32'd0);
      check("s6_pcnt", 32'(pcnt1), 32'd0);
      @(negedge clk);
      #1;
      check("s6_pass", 32'(pass1), 32'd0);
      check("s6_fail", 32'(fail1), 32'd0);
      rst_n = 1'b1;
      cyc(0, 1, 0);
      check("s6_trig", 32'(busy1), 32'd1);
      check("s6_src2", 32'(src1),  32'd1);
      cyc(0, 0, 1);
      check("s6_pass2", 32'(pass1), 32'd1);
      check("s6_pcnt2", 32'(pcnt1), 32'd1);
      cyc(0, 0, 0); cyc(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
